rv32i_psram_lsu: RTL and testbench

//  Load/store bridge between the rv32i_top MA stage and the 16-bit psram controller (cram0).

---
 rtl/rv32i_psram_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_rv32i_psram_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_psram_lsu.sv
// Load/store bridge from the rv32i MA stage to the 16-bit psram controller; splits word accesses into halfword ops.
// Optional one-entry read buffer enabled by defining RV32I_PSRAM_LSU_RDBUF_EN.
module rv32i_psram_lsu #(
    parameter int unsigned PSRAM_AW       = 22,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          BANK           = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [3:0]          req_be,
    input  logic [31:0]         req_wdata,
    output logic                core_stall,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                ps_bank_sel,
    output logic [PSRAM_AW-1:0] ps_addr,
    output logic                ps_write_en,
    output logic [15:0]         ps_data_in,
    output logic                ps_write_high_byte,
    output logic                ps_write_low_byte,
    output logic                ps_read_en,
    input  logic                ps_read_avail,
    input  logic [15:0]         ps_data_out,
    input  logic                ps_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TAG_W = PSRAM_AW - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE_LO, S_WAIT_LO, S_ISSUE_HI, S_WAIT_HI, S_DONE
    } state_t;

    state_t             state_q, state_next;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_seen_q;

    logic               accept;
    logic               timeout;
    logic               hit;
    logic               wait_done;
    logic [31:0]        rdata_c;
    logic [TAG_W-1:0]   req_tag;
    logic               cur_we;
    logic [3:0]         cur_be;
    logic [31:0]        cur_wdata;
    logic [TAG_W-1:0]   cur_tag;
    logic               unused_addr;

`ifdef RV32I_PSRAM_LSU_RDBUF_EN
    logic               rdbuf_valid;
    logic [TAG_W-1:0]   rdbuf_tag;
    logic [31:0]        rdbuf_data;
`endif

    assign req_tag     = req_addr[PSRAM_AW:2];
    assign unused_addr = ^{req_addr[31:PSRAM_AW+1], req_addr[1:0]};
    assign ps_bank_sel = BANK;

    // Request fields come straight from the port in the accept cycle, from the latch afterwards.
    assign cur_we    = accept ? req_we    : we_q;
    assign cur_be    = accept ? req_be    : be_q;
    assign cur_wdata = accept ? req_wdata : wdata_q;
    assign cur_tag   = accept ? req_tag   : tag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_next;
    end

    always_comb begin
        state_next  = state_q;
        core_stall  = 1'b1;
        ps_write_en = 1'b0;
        ps_read_en  = 1'b0;
        accept      = 1'b0;
        timeout     = 1'b0;
        hit         = 1'b0;
        wait_done   = 1'b0;
        rdata_c     = rdata_q;
        case (state_q)
            S_IDLE: begin
                core_stall = req_valid;
                if (req_valid) begin
                    accept = 1'b1;
                    if (!req_we) begin
`ifdef RV32I_PSRAM_LSU_RDBUF_EN
                        hit = rdbuf_valid && (rdbuf_tag == req_tag);
`endif
                        state_next = hit ? S_DONE : S_ISSUE_LO;
                    end else if (|req_be[1:0]) begin
                        state_next = S_ISSUE_LO;
                    end else if (|req_be[3:2]) begin
                        state_next = S_ISSUE_HI;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_ISSUE_LO, S_ISSUE_HI: begin
                // Strobe only once the controller is idle; this also drains an op abandoned by reset.
                if (!ps_busy) begin
                    ps_write_en = we_q;
                    ps_read_en  = !we_q;
                    state_next  = (state_q == S_ISSUE_LO) ? S_WAIT_LO : S_WAIT_HI;
                end
            end
            S_WAIT_LO, S_WAIT_HI: begin
                wait_done = we_q ? (busy_seen_q && !ps_busy) : ps_read_avail;
                if (!we_q && ps_read_avail) begin
                    if (state_q == S_WAIT_LO) rdata_c[15:0]  = ps_data_out;
                    else                      rdata_c[31:16] = ps_data_out;
                end
                if (wait_done) begin
                    state_next = (state_q == S_WAIT_HI || (we_q && !(|be_q[3:2]))) ? S_DONE : S_ISSUE_HI;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                core_stall = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q               <= 1'b0;
            be_q               <= 4'b0;
            wdata_q            <= 32'b0;
            rdata_q            <= 32'b0;
            tag_q              <= '0;
            cnt_q              <= '0;
            busy_seen_q        <= 1'b0;
            ps_addr            <= '0;
            ps_data_in         <= 16'b0;
            ps_write_high_byte <= 1'b0;
            ps_write_low_byte  <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= 32'b0;
            rsp_err            <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                be_q    <= req_be;
                wdata_q <= req_wdata;
                tag_q   <= req_tag;
                rdata_q <= 32'b0;
            end else begin
                rdata_q <= rdata_c;
            end

            // Counter and busy history are per WAIT visit; ISSUE always sits between two WAITs.
            if (state_q == S_WAIT_LO || state_q == S_WAIT_HI) begin
                cnt_q       <= cnt_q + CNT_W'(1);
                busy_seen_q <= busy_seen_q | ps_busy;
            end else begin
                cnt_q       <= '0;
                busy_seen_q <= 1'b0;
            end

            if (state_next == S_ISSUE_LO && state_q != S_ISSUE_LO) begin
                ps_addr            <= {cur_tag, 1'b0};
                ps_data_in         <= cur_wdata[15:0];
                ps_write_high_byte <= cur_be[1];
                ps_write_low_byte  <= cur_be[0];
            end else if (state_next == S_ISSUE_HI && state_q != S_ISSUE_HI) begin
                ps_addr            <= {cur_tag, 1'b1};
                ps_data_in         <= cur_wdata[31:16];
                ps_write_high_byte <= cur_be[3];
                ps_write_low_byte  <= cur_be[2];
            end

            rsp_valid <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                rsp_err <= timeout;
                if (timeout || cur_we) begin
                    rsp_rdata <= 32'b0;
                end else begin
`ifdef RV32I_PSRAM_LSU_RDBUF_EN
                    rsp_rdata <= hit ? rdbuf_data : rdata_c;
`else
                    rsp_rdata <= rdata_c;
`endif
                end
            end
        end
    end

`ifdef RV32I_PSRAM_LSU_RDBUF_EN
    // Buffer: filled by completed loads, patched by stores to the same word, dropped on timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdbuf_valid <= 1'b0;
            rdbuf_tag   <= '0;
            rdbuf_data  <= 32'b0;
        end else begin
            if (timeout) begin
                rdbuf_valid <= 1'b0;
            end else if (state_q == S_WAIT_HI && state_next == S_DONE && !we_q) begin
                rdbuf_valid <= 1'b1;
                rdbuf_tag   <= tag_q;
                rdbuf_data  <= rdata_c;
            end else if (accept && req_we && rdbuf_valid && rdbuf_tag == req_tag) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_be[i]) rdbuf_data[8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_psram_lsu.sv
// Directed self-checking bench for rv32i_psram_lsu with a small behavioural psram model.
// Halfword address on ps_addr is byte address >> 1.
module tb_rv32i_psram_lsu;

    localparam int unsigned AW = 22;
    localparam int unsigned TO = 255;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_be;
    logic          core_stall, rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          ps_bank_sel, ps_write_en, ps_read_en;
    logic [AW-1:0] ps_addr;
    logic [15:0]   ps_data_in;
    logic          ps_write_high_byte, ps_write_low_byte;
    logic          ps_read_avail = 1'b0;
    logic [15:0]   ps_data_out = 16'h0;
    logic          ps_busy;

    logic          force_busy = 1'b0;
    logic          mute_all = 1'b0;
    logic          mute_hi = 1'b0;
    int            busy_cnt = 0;
    int            rd_cnt = 0;
    int            rsp_cnt = 0;
    logic [39:0]   wr_log[$];
    logic [15:0]   mem [0:255] = '{default: 16'h0};

    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    rv32i_psram_lsu #(.PSRAM_AW(AW), .TIMEOUT_CYCLES(TO), .BANK(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .core_stall(core_stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ps_bank_sel(ps_bank_sel), .ps_addr(ps_addr), .ps_write_en(ps_write_en),
        .ps_data_in(ps_data_in), .ps_write_high_byte(ps_write_high_byte),
        .ps_write_low_byte(ps_write_low_byte), .ps_read_en(ps_read_en),
        .ps_read_avail(ps_read_avail), .ps_data_out(ps_data_out), .ps_busy(ps_busy)
    );

    assign ps_busy = force_busy | (busy_cnt != 0);

    // psram model: writes busy for 2 cycles, reads answer one cycle after the strobe.
    always @(posedge clk) begin
        ps_read_avail <= 1'b0;
        if (ps_write_en) begin
            wr_log.push_back({ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte});
            if (ps_write_low_byte)  mem[ps_addr[7:0]][7:0]  <= ps_data_in[7:0];
            if (ps_write_high_byte) mem[ps_addr[7:0]][15:8] <= ps_data_in[15:8];
            busy_cnt <= 2;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (ps_read_en) begin
            rd_cnt <= rd_cnt + 1;
            if (!mute_all && !(mute_hi && ps_addr[0])) begin
                ps_read_avail <= 1'b1;
                ps_data_out   <= mem[ps_addr[7:0]];
            end
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latency counts the request cycle as 1; returns -1 if no response within the budget.
    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 400);
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
        req_valid = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_valid = 1'b1;
    endtask

    int          lat, wr0, rd0, rs0;
    logic [31:0] rd;
    logic        er, stall_ok;

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(core_stall), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_strobes", 64'({ps_write_en, ps_read_en}), 64'(0));
        check("rst_ps_addr", 64'(ps_addr), 64'(0));
        check("rst_bank", 64'(ps_bank_sel), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Full-word store: LO then HI halfword writes.
        wr0 = wr_log.size(); rs0 = rsp_cnt;
        drive(1'b1, 32'h100, 4'b1111, 32'h12345678);
        wait_rsp(lat, rd, er);
        repeat (3) @(negedge clk);
        check("st1_err", 64'(er), 64'(0));
        check("st1_nwr", 64'(wr_log.size() - wr0), 64'(2));
        check("st1_wr_lo", 64'(wr_log[wr0]), 64'({22'h80, 16'h5678, 2'b11}));
        check("st1_wr_hi", 64'(wr_log[wr0+1]), 64'({22'h81, 16'h1234, 2'b11}));
        check("st1_nrsp", 64'(rsp_cnt - rs0), 64'(1));

        // Single-byte store in lane 2: HI op only, low byte lane.
        wr0 = wr_log.size();
        drive(1'b1, 32'h104, 4'b0100, 32'h00AB0000);
        wait_rsp(lat, rd, er);
        repeat (3) @(negedge clk);
        check("st2_err", 64'(er), 64'(0));
        check("st2_nwr", 64'(wr_log.size() - wr0), 64'(1));
        check("st2_wr", 64'(wr_log[wr0]), 64'({22'h83, 16'h00AB, 2'b01}));

        // Store with no enabled lanes completes without psram traffic.
        wr0 = wr_log.size();
        drive(1'b1, 32'h10C, 4'b0000, 32'hFFFFFFFF);
        wait_rsp(lat, rd, er);
        @(negedge clk);
        check("st0_lat", 64'(lat), 64'(2));
        check("st0_nwr", 64'(wr_log.size() - wr0), 64'(0));

        // Minimum-latency load.
        rd0 = rd_cnt;
        drive(1'b0, 32'h100, 4'b1111, 32'h0);
        wait_rsp(lat, rd, er);
        @(negedge clk);
        check("ld1_data", 64'(rd), 64'(32'h12345678));
        check("ld1_err", 64'(er), 64'(0));
        check("ld1_nrd", 64'(rd_cnt - rd0), 64'(2));
        check("ld1_lat", 64'(lat), 64'(6));

        // Load that never gets read data: timeout after TO wait cycles.
        mute_all = 1'b1;
        rd0 = rd_cnt;
        drive(1'b0, 32'h108, 4'b1111, 32'h0);
        wait_rsp(lat, rd, er);
        @(negedge clk);
        mute_all = 1'b0;
        check("to_err", 64'(er), 64'(1));
        check("to_data", 64'(rd), 64'(0));
        check("to_lat", 64'(lat), 64'(TO + 3));
        check("to_nrd", 64'(rd_cnt - rd0), 64'(1));

        // Controller busy at request: no strobe, core held.
        force_busy = 1'b1;
        rd0 = rd_cnt;
        stall_ok = 1'b1;
        drive(1'b0, 32'h104, 4'b1111, 32'h0);
        repeat (20) begin
            @(negedge clk);
            if (!core_stall || ps_read_en || ps_write_en) stall_ok = 1'b0;
        end
        check("busy_hold", 64'(stall_ok), 64'(1));
        check("busy_nrd", 64'(rd_cnt - rd0), 64'(0));
        force_busy = 1'b0;
        wait_rsp(lat, rd, er);
        @(negedge clk);
        check("busy_data", 64'(rd), 64'(32'h00AB0000));
        check("busy_err", 64'(er), 64'(0));

        // Reset while waiting on the HI read.
        mute_hi = 1'b1;
        drive(1'b0, 32'h100, 4'b1111, 32'h0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rmid_strobes", 64'({ps_write_en, ps_read_en}), 64'(0));
        check("rmid_stall_req1", 64'(core_stall), 64'(1));
        check("rmid_rsp", 64'(rsp_valid), 64'(0));
        req_valid = 1'b0;
        #1;
        check("rmid_stall_req0", 64'(core_stall), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        mute_hi = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h100, 4'b1111, 32'h0);
        wait_rsp(lat, rd, er);
        @(negedge clk);
        check("post_rst_data", 64'(rd), 64'(32'h12345678));
        check("post_rst_err", 64'(er), 64'(0));
        check("post_rst_lat", 64'(lat), 64'(6));

        // Repeat load of the same word.
        rd0 = rd_cnt;
        drive(1'b0, 32'h100, 4'b1111, 32'h0);
        wait_rsp(lat, rd, er);
        @(negedge clk);
        check("rep_data", 64'(rd), 64'(32'h12345678));
`ifdef RV32I_PSRAM_LSU_RDBUF_EN
        check("rep_lat", 64'(lat), 64'(2));
        check("rep_nrd", 64'(rd_cnt - rd0), 64'(0));
`else
        check("rep_lat", 64'(lat), 64'(6));
        check("rep_nrd", 64'(rd_cnt - rd0), 64'(2));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
